// File: rtl/invsqrt_pkg.sv
// Shared types, constants and seed-table generator for the binary32 inverse square root core.
package invsqrt_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        SEED   = 3'd2,
        ITER   = 3'd3,
        PACK   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP32_PINF = 32'h7F80_0000;
    localparam logic [31:0] FP32_NINF = 32'hFF80_0000;
    localparam int          BIAS      = 127;

    // Q1.frac_w estimate of 1/sqrt(m) at the midpoint of the LUT bucket; the MSB of idx
    // selects the odd-exponent range m' in [2,4). 16-bit bisection is ample for a seed.
    function automatic logic [63:0] seed_value(input int idx, input int seed_bits, input int frac_w);
        longint unsigned num, bound, lo, hi, mid;
        num   = (longint'(1) << seed_bits) + longint'(2 * (idx % (1 << (seed_bits - 1))) + 1);
        if ((idx >> (seed_bits - 1)) != 0) num = num * 2;
        bound = longint'(1) << (32 + seed_bits);
        lo    = 0;
        hi    = longint'(1) << 16;
        for (int i = 0; i < 20; i++) begin
            if (hi - lo > 1) begin
                mid = (lo + hi) / 2;
                if (mid * mid * num <= bound) lo = mid;
                else hi = mid;
            end
        end
        return 64'(lo << (frac_w - 16));
    endfunction

endpackage

// File: rtl/invsqrt_seed_rom.sv
// Combinational seed table for the Newton iteration, built from seed_value at elaboration.
module invsqrt_seed_rom
    import invsqrt_pkg::*;
#(
    parameter int SEED_BITS = 6,
    parameter int FRAC_W    = 30
) (
    input  logic [SEED_BITS-1:0] idx,
    output logic [FRAC_W:0]      seed
);

    logic [FRAC_W:0] lut [2**SEED_BITS];

    for (genvar i = 0; i < 2**SEED_BITS; i++) begin : g_lut
        localparam logic [63:0] V = seed_value(i, SEED_BITS, FRAC_W);
        assign lut[i] = V[FRAC_W:0];
    end

    assign seed = lut[idx];

endmodule

// File: rtl/invsqrt_nr.sv
// Iterative binary32 1/sqrt(x): seed LUT plus ITERATIONS Newton steps on one shared multiplier.
// Define INVSQRT_DENORM_EN to normalise subnormal inputs instead of flushing them to zero.
module invsqrt_nr
    import invsqrt_pkg::*;
#(
    parameter int ITERATIONS = 2,
    parameter int FRAC_W     = 30,
    parameter int SEED_BITS  = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] float_in,
    output logic [31:0] float_out,
    output logic        ready,
    output logic        busy,
    output logic [1:0]  flags
);

    localparam int W  = FRAC_W + 2;
    localparam int IW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [W-1:0]      THREE    = {2'b11, {FRAC_W{1'b0}}};
    localparam logic [FRAC_W-1:0] LOW_MASK = {23'd0, {(FRAC_W - 23){1'b1}}};
    localparam logic [FRAC_W-1:0] HALF     = LOW_MASK ^ (LOW_MASK >> 1);

    state_t              state_q, state_d;
    fp32_t               op_q, op_d;
    logic [1:0]          phase_q, phase_d;
    logic [IW-1:0]       iter_q, iter_d;
    logic [W-1:0]        m_q, m_d, y_q, y_d, tmp_q, tmp_d;
    logic signed [9:0]   k_q, k_d;
    logic [SEED_BITS-1:0] idx_q, idx_d;
    logic [31:0]         res_q, res_d;
    logic                ready_q, ready_d, spec_q, spec_d;
    logic [1:0]          flags_q, flags_d;
`ifdef INVSQRT_DENORM_EN
    logic                norm_q, norm_d;
    logic signed [9:0]   esub_q, esub_d;
    logic [23:0]         sub_v, sub_sh;
    logic [4:0]          lz;
`endif

    logic [FRAC_W:0]     seed;
    logic [W-1:0]        mul_a, mul_b, tsh, ysh;
    logic [2*W-1:0]      prod;
    logic [FRAC_W-1:0]   r, rem;
    logic [23:0]         mant;
    logic [7:0]          ex;
    logic                rnd, zero;
    logic signed [9:0]   e_in;
    logic [31:0]         pack_res;

    invsqrt_seed_rom #(.SEED_BITS(SEED_BITS), .FRAC_W(FRAC_W)) u_rom (.idx(idx_q), .seed(seed));

    // t = y*y, u = 3 - m'*t, y = y*u/2 all share this product
    always_comb begin
        unique case (phase_q)
            2'd0:    begin mul_a = y_q; mul_b = y_q;   end
            2'd1:    begin mul_a = m_q; mul_b = tmp_q; end
            default: begin mul_a = y_q; mul_b = tmp_q; end
        endcase
        prod = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
        tsh  = W'(prod >> FRAC_W);
        ysh  = W'(prod >> (FRAC_W + 1));
    end

    // r sits in (0.5,1]; the hidden bit is dropped from r, a rounding carry bumps the exponent
    always_comb begin
        r        = '0;
        rem      = '0;
        rnd      = 1'b0;
        mant     = '0;
        ex       = 8'(BIAS - int'(k_q));
        pack_res = {1'b0, ex, 23'd0};
        if (!y_q[FRAC_W]) begin
            if (y_q[FRAC_W-1]) begin
                r  = {y_q[FRAC_W-2:0], 1'b0};
                ex = 8'(BIAS - 1 - int'(k_q));
            end else begin
                r  = {y_q[FRAC_W-3:0], 2'b00};
                ex = 8'(BIAS - 2 - int'(k_q));
            end
            rem      = r & LOW_MASK;
            rnd      = (rem > HALF) || ((rem == HALF) && r[FRAC_W-23]);
            mant     = {1'b0, r[FRAC_W-1 -: 23]} + {23'd0, rnd};
            pack_res = mant[23] ? {1'b0, ex + 8'd1, 23'd0} : {1'b0, ex, mant[22:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        phase_d = phase_q;
        iter_d  = iter_q;
        m_d     = m_q;
        y_d     = y_q;
        tmp_d   = tmp_q;
        k_d     = k_q;
        idx_d   = idx_q;
        res_d   = res_q;
        ready_d = ready_q;
        spec_d  = spec_q;
        flags_d = flags_q;
`ifdef INVSQRT_DENORM_EN
        norm_d  = norm_q;
        esub_d  = esub_q;
        sub_v   = {1'b0, op_q.frac};
        lz      = 5'd0;
        for (int i = 0; i < 24; i++) if (sub_v[i]) lz = 5'(23 - i);
        sub_sh  = sub_v << lz;
        zero    = (op_q.exp == 8'd0) && (op_q.frac == 23'd0) && !norm_q;
        e_in    = norm_q ? esub_q : $signed({2'b00, op_q.exp}) - 10'sd127;
`else
        zero    = (op_q.exp == 8'd0);
        e_in    = $signed({2'b00, op_q.exp}) - 10'sd127;
`endif
        unique case (state_q)
            IDLE, DONE: if (start) begin
                op_d    = float_in;
                ready_d = 1'b0;
                flags_d = 2'b00;
                state_d = UNPACK;
`ifdef INVSQRT_DENORM_EN
                norm_d  = 1'b0;
`endif
            end
            UNPACK: begin
                state_d = PACK;
                spec_d  = 1'b1;
                if (op_q.exp == 8'hFF) begin
                    res_d   = (op_q.frac != 23'd0 || op_q.sign) ? FP32_QNAN : 32'd0;
                    flags_d = {(op_q.frac != 23'd0) ? ~op_q.frac[22] : op_q.sign, 1'b0};
                end else if (zero) begin
                    res_d   = op_q.sign ? FP32_NINF : FP32_PINF;
                    flags_d = 2'b01;
                end else if (op_q.sign) begin
                    res_d   = FP32_QNAN;
                    flags_d = 2'b10;
`ifdef INVSQRT_DENORM_EN
                end else if (op_q.exp == 8'd0 && !norm_q) begin
                    // subnormal: renormalise now, classify again next cycle
                    state_d   = UNPACK;
                    spec_d    = 1'b0;
                    norm_d    = 1'b1;
                    op_d.frac = sub_sh[22:0];
                    esub_d    = -10'sd126 - $signed({5'd0, lz});
`endif
                end else begin
                    spec_d  = 1'b0;
                    state_d = SEED;
                    k_d     = {e_in[9], e_in[9:1]};
                    m_d     = e_in[0] ? {1'b1, op_q.frac, {(FRAC_W - 22){1'b0}}}
                                      : {2'b01, op_q.frac, {(FRAC_W - 23){1'b0}}};
                    idx_d   = {e_in[0], op_q.frac[22 -: SEED_BITS-1]};
                end
            end
            SEED: begin
                y_d     = {1'b0, seed};
                phase_d = 2'd0;
                iter_d  = '0;
                state_d = ITER;
            end
            ITER: begin
                unique case (phase_q)
                    2'd0: begin tmp_d = tsh;         phase_d = 2'd1; end
                    2'd1: begin tmp_d = THREE - tsh; phase_d = 2'd2; end
                    default: begin
                        y_d     = ysh;
                        phase_d = 2'd0;
                        if (iter_q == IW'(ITERATIONS - 1)) state_d = PACK;
                        else iter_d = iter_q + 1'b1;
                    end
                endcase
            end
            PACK: begin
                if (!spec_q) res_d = pack_res;
                ready_d = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            phase_q <= '0;
            iter_q  <= '0;
            m_q     <= '0;
            y_q     <= '0;
            tmp_q   <= '0;
            k_q     <= '0;
            idx_q   <= '0;
            res_q   <= '0;
            ready_q <= 1'b0;
            spec_q  <= 1'b0;
            flags_q <= 2'b00;
`ifdef INVSQRT_DENORM_EN
            norm_q  <= 1'b0;
            esub_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            phase_q <= phase_d;
            iter_q  <= iter_d;
            m_q     <= m_d;
            y_q     <= y_d;
            tmp_q   <= tmp_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            ready_q <= ready_d;
            spec_q  <= spec_d;
            flags_q <= flags_d;
`ifdef INVSQRT_DENORM_EN
            norm_q  <= norm_d;
            esub_q  <= esub_d;
`endif
        end
    end

    assign float_out = res_q;
    assign ready     = ready_q;
    assign flags     = flags_q;
    assign busy      = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_invsqrt_nr.sv
// Directed-vector bench for invsqrt_nr: default core plus ITERATIONS=1/3 copies for latency.
module tb_invsqrt_nr;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] float_in;
    logic [31:0] float_out, float_out1, float_out3;
    logic        ready, ready1, ready3, busy, busy1, busy3;
    logic [1:0]  flags, flags1, flags3;

    int vecs = 0;
    int errs = 0;
    int lat, lat1, lat3;
    logic        bsy;
    logic [31:0] res;
    logic [1:0]  fl;

    always #5 clk = ~clk;

    invsqrt_nr dut (.clk(clk), .rst(rst), .start(start), .float_in(float_in),
                    .float_out(float_out), .ready(ready), .busy(busy), .flags(flags));
    invsqrt_nr #(.ITERATIONS(1)) dut1 (.clk(clk), .rst(rst), .start(start), .float_in(float_in),
                    .float_out(float_out1), .ready(ready1), .busy(busy1), .flags(flags1));
    invsqrt_nr #(.ITERATIONS(3)) dut3 (.clk(clk), .rst(rst), .start(start), .float_in(float_in),
                    .float_out(float_out3), .ready(ready3), .busy(busy3), .flags(flags3));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp, input int tol);
        longint d;
        vecs++;
        d = longint'(got) - longint'(exp);
        if (d < 0) d = -d;
        if (d > longint'(tol)) begin
            errs++;
            $display("FAIL %s: got %h, expected %h (tol %0d)", tag, got, exp, tol);
        end
    endtask

    // Launch x on all cores; optionally pulse a second start at cycle pulse_at (must be ignored).
    task automatic run_op(input logic [31:0] x, input int pulse_at);
        @(negedge clk);
        float_in = x;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bsy   = busy;
        lat = 0; lat1 = 0; lat3 = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == pulse_at) begin float_in = 32'h3F80_0000; start = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            if (ready  && lat  == 0) lat  = n;
            if (ready1 && lat1 == 0) lat1 = n;
            if (ready3 && lat3 == 0) lat3 = n;
            if (lat != 0 && lat1 != 0 && lat3 != 0) break;
        end
        start = 1'b0;
        res   = float_out;
        fl    = flags;
    endtask

    logic [31:0] sp_in  [7] = '{32'h0000_0000, 32'h8000_0000, 32'hC080_0000, 32'h7F80_0000,
                                32'hFF80_0000, 32'h7FA0_0000, 32'h7FC0_0000};
    logic [31:0] sp_out [7] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h0000_0000,
                                32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000};
    logic [1:0]  sp_fl  [7] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00};

    initial begin
        rst = 1'b1; start = 1'b0; float_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'd0, 0);
        chk("rst_busy",  64'(busy),  64'd0, 0);
        chk("rst_out",   64'(float_out), 64'd0, 0);
        chk("rst_flags", 64'(flags), 64'd0, 0);
        @(negedge clk) rst = 1'b0;

        run_op(32'h4080_0000, 0);
        chk("four_val",   64'(res), 64'h3F00_0000, 0);
        chk("four_flags", 64'(fl),  64'd0, 0);
        chk("four_lat",   64'(lat), 64'd9, 0);
        chk("four_busy",  64'(bsy), 64'd1, 0);
        chk("lat_iter1",  64'(lat1), 64'd6, 0);
        chk("lat_iter3",  64'(lat3), 64'd12, 0);

        run_op(32'h3F80_0000, 0);
        chk("one_val", 64'(res), 64'h3F80_0000, 0);
        run_op(32'h3D80_0000, 0);
        chk("sixteenth_val", 64'(res), 64'h4080_0000, 0);
        run_op(32'h4000_0000, 0);
        chk("two_val", 64'(res), 64'h3F35_04F3, 2);
        chk("two_flags", 64'(fl), 64'd0, 0);
        run_op(32'h7F7F_FFFF, 0);
        chk("max_val", 64'(res), 64'h1F80_0000, 2);

        for (int i = 0; i < 7; i++) begin
            run_op(sp_in[i], 0);
            chk($sformatf("sp%0d_val", i),   64'(res), 64'(sp_out[i]), 0);
            chk($sformatf("sp%0d_flags", i), 64'(fl),  64'(sp_fl[i]), 0);
            chk($sformatf("sp%0d_lat", i),   64'(lat), 64'd2, 0);
        end

        run_op(32'h0000_0001, 0);
`ifdef INVSQRT_DENORM_EN
        chk("sub_val",   64'(res), 64'h64B5_04F3, 2);
        chk("sub_flags", 64'(fl),  64'd0, 0);
`else
        chk("sub_val",   64'(res), 64'h7F80_0000, 0);
        chk("sub_flags", 64'(fl),  64'd1, 0);
`endif

        // abort: float_out still holds the previous result when rst hits
        run_op(32'h3F80_0000, 0);
        @(negedge clk);
        float_in = 32'h4080_0000;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_ready", 64'(ready), 64'd0, 0);
        chk("abort_out",   64'(float_out), 64'd0, 0);
        chk("abort_busy",  64'(busy), 64'd0, 0);
        @(negedge clk) rst = 1'b0;
        run_op(32'h4080_0000, 0);
        chk("post_abort_val", 64'(res), 64'h3F00_0000, 0);
        chk("post_abort_lat", 64'(lat), 64'd9, 0);

        run_op(32'h4080_0000, 3);
        chk("pulse_val", 64'(res), 64'h3F00_0000, 0);
        chk("pulse_lat", 64'(lat), 64'd9, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
